vend_sequencer: RTL
===================

Name: vend_sequencer

Overview:
- Central controller of the vending machine. It takes the one-cycle coin pulses from the coin receiver and a product selection, and accumulates credit against the selected product's price.
- When credit covers the price it triggers the dispense. It then pays change back coin-by-coin with a greedy algorithm and clears the coin receiver.
- It also handles cancel and inactivity timeout by refunding the whole credit.
- It drives the coin receiver's enough_payment and m_rst inputs.

Parameters:
- CW, 8, credit register width.
- PRICE_0, 7, price of product 0.
- PRICE_1, 12, price of product 1.
- PRICE_2, 25, price of product 2.
- PRICE_3, 40, price of product 3.
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before auto-refund (minimum 2).

Ports:
- clk  in  1  system clock.
- i_rst  in  1  asynchronous active-high reset.
- on_m_1, on_m_5, on_m_10, on_m_20  in  1 each  one-cycle coin pulses from the coin receiver.
- cancel  in  1  cancel level from the coin receiver (o_cancel).
- sel_valid  in  1  product-select strobe.
- sel_id  in  2  product index, sampled with sel_valid.
- enough_payment  out  1  blocks coin acceptance in the coin receiver.
- m_rst  out  1  one-cycle clear pulse to the coin receiver.
- dispense  out  1  one-cycle vend pulse.
- dispense_id  out  2  product index, valid with dispense.
- ret_1, ret_5, ret_10, ret_20  out  1 each  one-cycle change/refund coin pulses.
- credit  out  CW  current credit.
- busy  out  1  high in VEND, CHANGE, REFUND and CLEAR.

Behaviour:
- Reset (async, i_rst=1): state=IDLE, credit=0, no selection latched, timeout counter=0. All outputs are 0. Reset mid-operation aborts any change sequence; no further ret_x pulses are issued.
- Coin value: at most one on_m_x is high per cycle (guaranteed by the receiver). Its value (1/5/10/20) is added to credit in IDLE and COLLECT only. Credit saturates at 2^CW-1.
- Coin pulses in VEND, CHANGE, REFUND and CLEAR are ignored.
- States: IDLE, COLLECT, VEND, CHANGE, REFUND, CLEAR.
- IDLE:
  - sel_valid latches sel_id and its price, then goes to COLLECT.
  - Coins accumulate in IDLE before any selection.
  - cancel with credit>0 goes to REFUND; cancel with credit=0 goes to CLEAR.
  - sel_valid and cancel in the same cycle: cancel wins.
- COLLECT:
  - If the effective credit (including a coin arriving this cycle) is >= price, next state is VEND.
  - cancel goes to REFUND (credit>0) or CLEAR (credit=0). A coin arriving in the cancel cycle is counted and then refunded.
  - sel_valid is ignored; the selection is fixed once latched.
  - The timeout counter resets on every coin and on entry. When it reaches TIMEOUT_CYC-1 with no coin, next state is REFUND (credit>0) or CLEAR (credit=0).
- VEND (1 cycle): dispense=1, dispense_id=latched index, credit<=credit-price, then CHANGE.
- CHANGE and REFUND: identical greedy engine.
  - If credit=0, go to CLEAR.
  - Otherwise alternate an issue cycle and a gap cycle.
  - Issue cycle: pulse the largest denomination <= credit (20 > 10 > 5 > 1) and subtract it from credit.
  - Gap cycle: all ret_x = 0.
  - REFUND never asserts dispense.
- CLEAR (1 cycle): m_rst=1, clear selection and timeout counter, then IDLE.
- enough_payment: registered output.
  - 1 in VEND, CHANGE, REFUND and CLEAR.
  - 1 in IDLE/COLLECT from the cycle after credit >= latched price.
  - 0 otherwise.
- Latency: sufficient coin pulse at cycle N gives dispense at N+1 and the first ret_x at N+2 (if change is due). m_rst follows the last ret gap by 1 cycle.
- credit output reflects the register value every cycle. At most one ret_x is high per cycle.

Test Plan:
- Reset, select 0 (price 7), coins 5,5 → dispense=1 (id 0) one cycle after the 2nd coin; ret_1 pulsed 3 times, 2 cycles apart; m_rst pulse; credit=0; state IDLE.
- Select 2 (price 25), coins 20,5 → dispense (id 2), no ret_x, m_rst one cycle after CHANGE entry, enough_payment=1 from VEND until IDLE.
- No selection, coin 20, then select 0 → vend immediately; change 13 returned as ret_10, ret_1, ret_1, ret_1.
- Select 3, coins 10,1, then cancel → ret_10, ret_1, m_rst; dispense never asserted. Cancel with a simultaneous coin 5 → refund 10,5,1.
- Select 1, coin 5, wait TIMEOUT_CYC cycles → ret_5 then m_rst. Timeout with credit=0 → m_rst only.
- Select 0, coin 20, assert i_rst during the first ret gap → all outputs 0 immediately, credit=0, no further ret_x; a fresh transaction afterwards is correct.

Source files
------------

// File: rtl/vend_sequencer.sv
// Vending machine controller: credit accumulation, vend trigger,
// greedy coin-by-coin change/refund and coin receiver clearing.
module vend_sequencer #(
   parameter int CW          = 8,
   parameter int PRICE_0     = 7,
   parameter int PRICE_1     = 12,
   parameter int PRICE_2     = 25,
   parameter int PRICE_3     = 40,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic          clk,
   input  logic          i_rst,
   input  logic          on_m_1,
   input  logic          on_m_5,
   input  logic          on_m_10,
   input  logic          on_m_20,
   input  logic          cancel,
   input  logic          sel_valid,
   input  logic [1:0]    sel_id,
   output logic          enough_payment,
   output logic          m_rst,
   output logic          dispense,
   output logic [1:0]    dispense_id,
   output logic          ret_1,
   output logic          ret_5,
   output logic          ret_10,
   output logic          ret_20,
   output logic [CW-1:0] credit,
   output logic          busy
);

   typedef enum logic [2:0] {
      S_IDLE, S_COLLECT, S_VEND, S_CHANGE, S_REFUND, S_CLEAR
   } state_t;

   localparam int TW = $clog2(TIMEOUT_CYC) + 1;
   localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);

   state_t        r_state, w_nstate;
   logic [CW-1:0] r_credit, w_ncredit;
   logic [CW-1:0] r_price, w_nprice;
   logic [1:0]    r_sel, w_nsel;
   logic          r_has, w_nhas;
   logic [TW-1:0] r_tmo, w_ntmo;
   logic          r_gap, w_ngap;
   logic          r_ep, w_nep;

   logic [CW:0]   w_coin;
   logic [CW:0]   w_sum;
   logic [CW-1:0] w_eff;
   logic [CW-1:0] w_den;
   logic [CW-1:0] w_sel_price;
   logic          w_issue;
   state_t        w_abort;

   always_comb begin
      w_coin = '0;
      unique case (1'b1)
         on_m_20: w_coin = (CW+1)'(20);
         on_m_10: w_coin = (CW+1)'(10);
         on_m_5:  w_coin = (CW+1)'(5);
         on_m_1:  w_coin = (CW+1)'(1);
         default: w_coin = '0;
      endcase
   end

   // credit saturates instead of wrapping
   assign w_sum = {1'b0, r_credit} + w_coin;
   assign w_eff = w_sum[CW] ? {CW{1'b1}} : w_sum[CW-1:0];
   assign w_abort = (w_eff != '0) ? S_REFUND : S_CLEAR;

   always_comb begin
      w_sel_price = CW'(PRICE_0);
      case (sel_id)
         2'd1:    w_sel_price = CW'(PRICE_1);
         2'd2:    w_sel_price = CW'(PRICE_2);
         2'd3:    w_sel_price = CW'(PRICE_3);
         default: w_sel_price = CW'(PRICE_0);
      endcase
   end

   always_comb begin
      w_den = CW'(1);
      if (r_credit >= CW'(20))      w_den = CW'(20);
      else if (r_credit >= CW'(10)) w_den = CW'(10);
      else if (r_credit >= CW'(5))  w_den = CW'(5);
   end

   assign w_issue = (r_state == S_CHANGE || r_state == S_REFUND)
                    && !r_gap && (r_credit != '0);

   always_comb begin
      w_nstate  = r_state;
      w_ncredit = r_credit;
      w_nprice  = r_price;
      w_nsel    = r_sel;
      w_nhas    = r_has;
      w_ntmo    = r_tmo;
      w_ngap    = r_gap;
      case (r_state)
         S_IDLE: begin
            w_ncredit = w_eff;
            if (cancel) begin
               w_nstate = w_abort;
               w_ngap   = 1'b0;
            end else if (sel_valid) begin
               w_nstate = S_COLLECT;
               w_nsel   = sel_id;
               w_nprice = w_sel_price;
               w_nhas   = 1'b1;
               w_ntmo   = '0;
            end
         end
         S_COLLECT: begin
            w_ncredit = w_eff;
            if (cancel) begin
               w_nstate = w_abort;
               w_ngap   = 1'b0;
            end else if (w_eff >= r_price) begin
               w_nstate = S_VEND;
            end else if (w_coin != '0) begin
               w_ntmo = '0;
            end else if (r_tmo == TMAX) begin
               w_nstate = w_abort;
               w_ngap   = 1'b0;
            end else begin
               w_ntmo = r_tmo + TW'(1);
            end
         end
         S_VEND: begin
            w_ncredit = r_credit - r_price;
            w_nstate  = S_CHANGE;
            w_ngap    = 1'b0;
         end
         S_CHANGE, S_REFUND: begin
            // issue and gap cycles alternate until credit is drained
            if (r_credit == '0) begin
               w_nstate = S_CLEAR;
            end else if (r_gap) begin
               w_ngap = 1'b0;
            end else begin
               w_ncredit = r_credit - w_den;
               w_ngap    = 1'b1;
            end
         end
         S_CLEAR: begin
            w_nstate = S_IDLE;
            w_nhas   = 1'b0;
            w_nsel   = '0;
            w_nprice = '0;
            w_ntmo   = '0;
            w_ngap   = 1'b0;
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   assign w_nep = (w_nstate inside {S_VEND, S_CHANGE, S_REFUND, S_CLEAR})
                  || (w_nhas && (w_ncredit >= w_nprice));

   always_ff @(posedge clk or posedge i_rst) begin
      if (i_rst) begin
         r_state  <= S_IDLE;
         r_credit <= '0;
         r_price  <= '0;
         r_sel    <= '0;
         r_has    <= 1'b0;
         r_tmo    <= '0;
         r_gap    <= 1'b0;
         r_ep     <= 1'b0;
      end else begin
         r_state  <= w_nstate;
         r_credit <= w_ncredit;
         r_price  <= w_nprice;
         r_sel    <= w_nsel;
         r_has    <= w_nhas;
         r_tmo    <= w_ntmo;
         r_gap    <= w_ngap;
         r_ep     <= w_nep;
      end
   end

   assign dispense       = (r_state == S_VEND);
   assign dispense_id    = dispense ? r_sel : 2'd0;
   assign ret_20         = w_issue && (w_den == CW'(20));
   assign ret_10         = w_issue && (w_den == CW'(10));
   assign ret_5          = w_issue && (w_den == CW'(5));
   assign ret_1          = w_issue && (w_den == CW'(1));
   assign m_rst          = (r_state == S_CLEAR);
   assign busy           = r_state inside {S_VEND, S_CHANGE, S_REFUND, S_CLEAR};
   assign credit         = r_credit;
   assign enough_payment = r_ep;

endmodule
